// File: rtl/ssp_apb_pkg.sv
// Shared types for the SSP APB command master.
// Holds the APB FSM state encoding, the command record and bus widths.
package ssp_apb_pkg;

   localparam int SSP_AW = 10;
   localparam int SSP_DW = 16;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_state_e;

   typedef struct packed {
      logic              write;
      logic [SSP_AW-1:0] addr;
      logic [SSP_DW-1:0] wdata;
   } ssp_cmd_t;

endpackage

// File: rtl/ssp_cmd_fifo.sv
// Command FIFO, DEPTH x ssp_cmd_t, first-word-fall-through head.
// Ports: clk_i/rst_i (async high), push_i/din_i, pop_i/head_o,
//        full_o/empty_o status flags.
module ssp_cmd_fifo
   import ssp_apb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  ssp_cmd_t din_i,
   input  logic     pop_i,
   output ssp_cmd_t head_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   ssp_cmd_t    mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   // Extra pointer MSB tells a wrapped-full FIFO from an empty one.
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

   assign head_o = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ssp_apb_cmd_master.sv
// APB3 requester feeding the SSP register slave from a command FIFO.
// Ports: cmd_* in (valid/ready), rsp_* out (valid/ready), APB master
//        P* signals, busy status; PCLK clock, PRESET async high reset.
module ssp_apb_cmd_master
   import ssp_apb_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [SSP_AW-1:0] cmd_addr,
   input  logic [SSP_DW-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [SSP_DW-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [SSP_AW-1:0] PADDR,
   output logic [SSP_DW-1:0] PWDATA,
   input  logic [SSP_DW-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR,
   output logic              busy
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   apb_state_e        state_q;
   logic [CW-1:0]     wait_q;
   logic              psel_q;
   logic              pen_q;
   logic              pwrite_q;
   logic [SSP_AW-1:0] paddr_q;
   logic [SSP_DW-1:0] pwdata_q;
   logic              rsp_valid_q;
   logic              rsp_write_q;
   logic [SSP_DW-1:0] rsp_rdata_q;
   logic              rsp_err_q;

   ssp_cmd_t fifo_din;
   ssp_cmd_t head;
   logic     fifo_full;
   logic     fifo_empty;
   logic     push;
   logic     pop;
   logic     rsp_free;

   assign cmd_ready = !fifo_full && !PRESET;
   assign push      = cmd_valid && cmd_ready;

   assign fifo_din.write = cmd_write;
   assign fifo_din.addr  = cmd_addr;
   assign fifo_din.wdata = cmd_wdata;

   // A response popped this cycle frees the slot for the next transfer.
   assign rsp_free = !rsp_valid_q || rsp_ready;
   assign pop      = (state_q == IDLE) && !fifo_empty && rsp_free;

   ssp_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (PCLK),
      .rst_i   (PRESET),
      .push_i  (push),
      .din_i   (fifo_din),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         psel_q      <= 1'b0;
         pen_q       <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  psel_q   <= 1'b1;
                  pen_q    <= 1'b0;
                  pwrite_q <= head.write;
                  paddr_q  <= head.addr;
                  pwdata_q <= head.wdata;
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               pen_q   <= 1'b1;
               wait_q  <= '0;
               state_q <= ACCESS;
            end
            ACCESS: begin
               if (PREADY || wait_q == TO_LAST) begin
                  // Normal completion or timeout abort.
                  rsp_valid_q <= 1'b1;
                  rsp_write_q <= pwrite_q;
                  rsp_rdata_q <= (PREADY && !pwrite_q) ? PRDATA : '0;
                  rsp_err_q   <= PREADY ? PSLVERR : 1'b1;
                  psel_q      <= 1'b0;
                  pen_q       <= 1'b0;
                  pwrite_q    <= 1'b0;
                  paddr_q     <= '0;
                  pwdata_q    <= '0;
                  state_q     <= IDLE;
               end else begin
                  wait_q <= wait_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign PSEL      = psel_q;
   assign PENABLE   = pen_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_write = rsp_write_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign busy      = !fifo_empty || (state_q != IDLE) || rsp_valid_q;

endmodule
